// File: rtl/debug_mem_arbiter.sv
// Shares one memory port between the CPU (req/ack pass-through) and the JTAG debug side.
// Debug strobe to memory request takes 2 cycles; completion pulses come 1 cycle after mem_ack or timeout.
// A busy debug side drops new strobes and flags dbg_overrun; a CPU request stalls while debug owns the bus.
module debug_mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_p,
  input  logic              dbg_ce,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rdata_ready,
  output logic              dbg_done,
  output logic              dbg_error,
  output logic              dbg_overrun,
  output logic              dbg_busy,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  // Counter is wide enough to hold TIMEOUT; a zero TIMEOUT disables the abort path.
  localparam int TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TERM_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] TERM = TW'(TERM_I);
  localparam bit TMO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CPU  = 2'd1,
    S_DBG  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                pend_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [TW-1:0]       tmo_cnt_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ready_q;
  logic                done_q;
  logic                error_q;
  logic                overrun_q;

  logic                capture;
  logic                dbg_ack;
  logic                dbg_tmo;
  logic                dbg_end;

  assign dbg_busy = pend_q | (state_q == S_DBG);
  assign capture  = dbg_ce & ~dbg_busy;
  assign dbg_ack  = (state_q == S_DBG) & mem_ack;
  // An ack in the terminal-count cycle takes precedence over the abort.
  assign dbg_tmo  = (state_q == S_DBG) & ~mem_ack & TMO_EN & (tmo_cnt_q == TERM);
  assign dbg_end  = dbg_ack | dbg_tmo;

  assign dbg_rdata       = rdata_q;
  assign dbg_rdata_ready = ready_q;
  assign dbg_done        = done_q;
  assign dbg_error       = error_q;
  assign dbg_overrun     = overrun_q;
  assign cpu_rdata       = mem_rdata;
  assign cpu_ack         = mem_ack & (state_q == S_CPU);

  // State register.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: debug wins ties, including a strobe being captured this very cycle,
  // so a CPU request raised together with dbg_ce waits behind the debug transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pend_q)                 state_d = S_DBG;
        else if (cpu_req & ~capture) state_d = S_CPU;
      end
      S_CPU:   if (mem_ack) state_d = S_IDLE;
      S_DBG:   if (dbg_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory bus mux decoded from state, so reset drops mem_req immediately.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_CPU: begin
        mem_req   = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      S_DBG: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  // Debug request capture and pending flag; pend clears on ack or abort.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      pend_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (capture) begin
        pend_q  <= 1'b1;
        we_q    <= dbg_we;
        addr_q  <= dbg_addr;
        wdata_q <= dbg_wdata;
      end else if (dbg_end) begin
        pend_q  <= 1'b0;
      end
    end
  end

  // Timeout counter: held at zero outside DBG, saturates rather than wrapping.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p)                       tmo_cnt_q <= '0;
    else if (state_q != S_DBG)       tmo_cnt_q <= '0;
    else if (tmo_cnt_q != {TW{1'b1}}) tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  // Read data register and one-cycle status pulses.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (dbg_ack & ~we_q) rdata_q <= mem_rdata;
      ready_q   <= dbg_ack & ~we_q;
      done_q    <= dbg_ack;
      error_q   <= dbg_tmo;
      overrun_q <= dbg_ce & dbg_busy;
    end
  end

endmodule

// File: tb/tb_debug_mem_arbiter.sv
// Randomized bench for debug_mem_arbiter with a transaction-level model:
// a sparse memory, a programmable ack latency and per-transfer cycle expectations.
module tb_debug_mem_arbiter;

  localparam int TMO = 4;

  logic        clk;
  logic        rst_p;
  logic        dbg_ce, dbg_we;
  logic [63:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        dbg_rdata_ready, dbg_done, dbg_error, dbg_overrun, dbg_busy;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  debug_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_p(rst_p),
    .dbg_ce(dbg_ce), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_rdata_ready(dbg_rdata_ready), .dbg_done(dbg_done),
    .dbg_error(dbg_error), .dbg_overrun(dbg_overrun), .dbg_busy(dbg_busy),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Sparse memory model; untouched locations read back a fixed hash of the address.
  logic [63:0] mem_model [logic [63:0]];
  logic [63:0] last_rdata = 64'd0;
  int          ack_lat    = 0;
  bit          ack_never  = 1'b0;

  function automatic logic [63:0] rd_model(input logic [63:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  // Memory responder: acks in request cycle ack_lat (0 = first), or never.
  initial begin
    int req_cyc;
    req_cyc   = 0;
    mem_ack   = 1'b0;
    mem_rdata = 64'd0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (!ack_never && req_cyc == ack_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = rd_model(mem_addr);
          if (mem_we) mem_model[mem_addr] = mem_wdata;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = {$urandom, $urandom};
        end
        req_cyc++;
      end else begin
        mem_ack = 1'b0;
        req_cyc = 0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // One debug transfer; called at a sample point in an idle, non-busy cycle (cycle N).
  // The memory holds mem_req for d cycles starting at N+2; pulses land at N+2+d.
  task automatic dbg_xfer(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                          input int lat, input bit never, input int ovr_at);
    int d;
    logic [63:0] exp_rd;
    d         = never ? TMO : lat + 1;
    exp_rd    = rd_model(addr);
    ack_lat   = lat;
    ack_never = never;
    dbg_ce    = 1'b1;
    dbg_we    = we;
    dbg_addr  = addr;
    dbg_wdata = wdata;
    for (int k = 1; k <= 2 + d; k++) begin
      step();
      check_val("mem_req",  64'(mem_req),  64'(k >= 2 && k <= 1 + d));
      check_val("dbg_busy", 64'(dbg_busy), 64'(k <= 1 + d));
      if (mem_req) begin
        check_val("mem_addr", mem_addr, addr);
        check_val("mem_we",   64'(mem_we), 64'(we));
        if (we) check_val("mem_wdata", mem_wdata, wdata);
      end
      check_val("dbg_done",    64'(dbg_done),        64'(!never && k == 2 + d));
      check_val("dbg_error",   64'(dbg_error),       64'(never && k == 2 + d));
      check_val("rdata_ready", 64'(dbg_rdata_ready), 64'(!never && !we && k == 2 + d));
      check_val("dbg_overrun", 64'(dbg_overrun),     64'(k == ovr_at + 1));
      check_val("cpu_ack_dbg", 64'(cpu_ack), 64'd0);
      if (k == 2 + d && !never && !we) begin
        check_val("dbg_rdata", dbg_rdata, exp_rd);
        last_rdata = exp_rd;
      end
      if (k == 2 + d && never) check_val("rdata_kept", dbg_rdata, last_rdata);
      dbg_ce    = (k == ovr_at);
      dbg_we    = ~we;
      dbg_addr  = (k == ovr_at) ? (addr ^ 64'hBAD0) : addr;
      dbg_wdata = ~wdata;
    end
    dbg_ce = 1'b0;
  endtask

  // One CPU transfer; called at a sample point in an idle cycle; returns in the following idle cycle.
  task automatic cpu_xfer(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                          input int lat);
    logic [63:0] exp_rd;
    exp_rd    = rd_model(addr);
    ack_lat   = lat;
    ack_never = 1'b0;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    for (int k = 1; k <= 1 + lat; k++) begin
      step();
      check_val("cpu_mem_req",  64'(mem_req), 64'd1);
      check_val("cpu_mem_addr", mem_addr, addr);
      check_val("cpu_mem_we",   64'(mem_we), 64'(we));
      check_val("cpu_ack",      64'(cpu_ack), 64'(k == 1 + lat));
      if (k == 1 + lat && !we) check_val("cpu_rdata", cpu_rdata, exp_rd);
      check_val("cpu_busy", 64'(dbg_busy), 64'd0);
    end
    cpu_req = 1'b0;
    step();
    check_val("cpu_idle", 64'(mem_req), 64'd0);
  endtask

  initial begin
    logic [63:0] a, w;
    int          lat, d, ovr, r;
    bit          nv, we;

    rst_p = 1'b1;
    dbg_ce = 1'b0; dbg_we = 1'b0; dbg_addr = 64'd0; dbg_wdata = 64'd0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 64'd0; cpu_wdata = 64'd0;
    mem_model[64'h100] = 64'hDEAD_BEEF_CAFE_F00D;

    step();
    step();
    check_val("rst_mem_req", 64'(mem_req),         64'd0);
    check_val("rst_busy",    64'(dbg_busy),        64'd0);
    check_val("rst_rdata",   dbg_rdata,            64'd0);
    check_val("rst_pulses",  64'({dbg_rdata_ready, dbg_done, dbg_error, dbg_overrun}), 64'd0);
    rst_p = 1'b0;
    step();

    // Zero-wait read, then a write and a read-back of the same location.
    dbg_xfer(1'b0, 64'h100, 64'd0, 0, 1'b0, -1);
    dbg_xfer(1'b1, 64'h8, 64'h55, 1, 1'b0, -1);
    dbg_xfer(1'b0, 64'h8, 64'd0, 2, 1'b0, -1);

    // CPU and debug strobe in the same idle cycle: debug first, then CPU.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h100; cpu_wdata = 64'd0;
    dbg_xfer(1'b1, 64'h10, 64'h1234, 1, 1'b0, -1);
    cpu_xfer(1'b0, 64'h100, 64'd0, 1);

    // Timeout with no ack, then ack in the terminal-count cycle.
    dbg_xfer(1'b0, 64'h18, 64'd0, 0, 1'b1, -1);
    dbg_xfer(1'b0, 64'h18, 64'd0, TMO - 1, 1'b0, -1);

    // Overrun mid-transfer and in the completion cycle.
    dbg_xfer(1'b0, 64'h20, 64'd0, 2, 1'b0, 2);
    dbg_xfer(1'b1, 64'h28, 64'h77, 1, 1'b0, 3);

    // Reset while debug owns the bus.
    ack_never = 1'b1;
    dbg_ce = 1'b1; dbg_we = 1'b0; dbg_addr = 64'h30;
    step();
    dbg_ce = 1'b0;
    step();
    check_val("pre_rst_req", 64'(mem_req), 64'd1);
    rst_p = 1'b1;
    #1;
    check_val("mid_rst_req",   64'(mem_req),  64'd0);
    check_val("mid_rst_busy",  64'(dbg_busy), 64'd0);
    check_val("mid_rst_rdata", dbg_rdata,     64'd0);
    check_val("mid_rst_pulse", 64'({dbg_rdata_ready, dbg_done, dbg_error, dbg_overrun}), 64'd0);
    step();
    rst_p = 1'b0;
    last_rdata = 64'd0;
    for (int i = 0; i < 6; i++) begin
      step();
      check_val("post_rst_quiet", 64'({mem_req, dbg_done, dbg_error, dbg_busy}), 64'd0);
    end
    dbg_xfer(1'b0, 64'h100, 64'd0, 1, 1'b0, -1);

    // Randomized mix of debug, CPU and tied transfers over a small address window.
    for (int it = 0; it < 60; it++) begin
      r   = int'($urandom_range(0, 9));
      a   = 64'($urandom_range(0, 7)) << 3;
      w   = {$urandom, $urandom};
      we  = bit'($urandom_range(0, 1));
      lat = int'($urandom_range(0, TMO - 1));
      nv  = ($urandom_range(0, 5) == 0);
      d   = nv ? TMO : lat + 1;
      ovr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 1 + d)) : -1;
      if (r < 6) begin
        dbg_xfer(we, a, w, lat, nv, ovr);
      end else if (r < 9) begin
        cpu_xfer(we, a, w, lat);
      end else begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a ^ 64'h8; cpu_wdata = 64'd0;
        dbg_xfer(we, a, w, lat, nv, -1);
        cpu_xfer(1'b0, a ^ 64'h8, 64'd0, int'($urandom_range(0, 3)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
